adc_serial_rx: RTL and testbench
================================

Name: adc_serial_rx

Overview:
- Upstream feeder of the QCW over-current detector.
- Drives a 10-bit serial current-sense ADC with a 16-bit frame: 4 leading zeros, 10 data bits MSB first, 2 trailing zeros. SCLK idles high; data is sampled on SCLK rising edges.
- Presents each converted code as the parallel 10-bit `adc_dout` that the OCD stage consumes.
- Converts back-to-back while enabled, at a fixed, deterministic sample rate.

Parameters:
- CLK_DIV, 4: `clk` cycles per SCLK half-period (>=2).
- QUIET_CYCLES, 2: `clk` cycles `adc_cs_n` stays high between frames (>=1).
- FRAME_BITS, 16: SCLK rising edges per frame (fixed format; not meant to be changed).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  run continuous conversions while high
- adc_sdata  in  1  ADC serial data
- adc_cs_n  out  1  ADC chip select, active low
- adc_sclk  out  1  ADC serial clock, idles high
- adc_dout  out  10  latest conversion code, offset-binary, 512 = zero current
- sample_valid  out  1  one-cycle pulse when `adc_dout` updates
- frame_err  out  1  one-cycle pulse, coincident with frame end, when any leading bit was 1
- err_count  out  8  saturating count of frame errors

Behaviour:
- Interface fixed: one clock `clk`; `rst_n` is asynchronous, active-low.
- Reset values:
  - `adc_cs_n`=1, `adc_sclk`=1.
  - `adc_dout`=512 (mid-scale, so downstream sees zero current).
  - `sample_valid`=0, `frame_err`=0, `err_count`=0.
  - State IDLE, all counters 0.
- Reset asserted mid-frame aborts the frame immediately, with the reset values above.
- All outputs are registered.
- FSM states: IDLE, CONVERT, QUIET.
- IDLE:
  - `adc_cs_n`=1, `adc_sclk`=1.
  - `enable`=1 -> CONVERT on the next cycle; `adc_cs_n` goes 0 that cycle, called frame cycle 0.
- CONVERT:
  - A half-period tick occurs every CLK_DIV cycles, at frame cycles CLK_DIV, 2·CLK_DIV, … 32·CLK_DIV.
  - Odd ticks drive `adc_sclk` low; even ticks drive it high and shift `adc_sdata` into a 16-bit shift register, MSB first.
  - On the 16th rising edge (frame cycle 32·CLK_DIV; 128 at defaults), the next cycle:
    - loads `adc_dout` from shift bits [11:2];
    - pulses `sample_valid`;
    - pulses `frame_err` if shift bits [15:12] != 0, and increments `err_count` (saturates at 255, no wrap);
    - drives `adc_cs_n`=1 and enters QUIET.
- QUIET:
  - `adc_cs_n`=1 for exactly QUIET_CYCLES cycles.
  - Then, if `enable`=1, go to CONVERT (`adc_cs_n`=0); otherwise go to IDLE.
- Timing:
  - Frame-start to `sample_valid`: 32·CLK_DIV+1 cycles.
  - Continuous frame period: 32·CLK_DIV+QUIET_CYCLES+1 cycles (131 at defaults).
- `enable` falling mid-frame: the frame completes normally, including its `sample_valid`, then the block goes to IDLE. Partial frames are never emitted.
- `enable` toggling during QUIET: only the level at QUIET exit matters.
- `adc_sclk` never glitches. It is high whenever `adc_cs_n`=1 and high at `adc_cs_n` transitions.
- Trailing bits [1:0] are ignored.

Optional Feature:
- Macro: `ADC_ERR_HOLD_EN`.
- Defined: on a frame error, `adc_dout` holds its previous value and `sample_valid` is suppressed. `frame_err` and `err_count` behave as without the macro.
- Undefined: `adc_dout` updates and `sample_valid` pulses on every frame, errored or not.

Decomposition:
- Package `adc_pkg`:
  - ADC_MIDSCALE=10'd512;
  - ADC_DATA_W=10;
  - FRAME_BITS=16 and the lead/trail bit counts (4/2);
  - the FSM state enum.
- Sub-module `adc_sclk_gen`: CLK_DIV tick counter plus SCLK toggle and edge-count, with start/busy/rise outputs. The top holds the FSM, shift register and error logic.

Test Plan:
- Reset, then hold `enable`=0 for 500 cycles -> `adc_cs_n`=1, `adc_sclk`=1, `adc_dout`=512, no `sample_valid`.
- ADC model returns frame 0x0_2A8<<2 (code 0x2A8=680), `enable`=1 -> `sample_valid` 129 cycles after `adc_cs_n` falls, `adc_dout`=680.
- Continuous `enable`, model cycles codes 0, 1023, 512 -> `sample_valid` every 131 cycles and `adc_dout` sequence 0, 1023, 512. Check 8 SCLK falling/rising edge pairs of 4 cycles each per half-frame.
- Model drives leading bits 4'b0100 with code 300 -> `frame_err` pulse, `err_count`=1. Without the macro, `adc_dout`=300 with `sample_valid`; with `ADC_ERR_HOLD_EN`, `adc_dout` unchanged and no `sample_valid`.
- Inject 300 consecutive errored frames -> `err_count` stops at 255.
- Drop `enable` at frame cycle 60, then assert `rst_n`=0 mid-frame on a second run:
  - first case: frame completes with `sample_valid`, then IDLE;
  - second case: immediate `adc_cs_n`=1, `adc_sclk`=1, `adc_dout`=512.

Source files
------------

// File: rtl/adc_serial_rx_pkg.sv
// Shared constants and FSM state encoding for the serial current-sense ADC receiver.
package adc_pkg;

   localparam int unsigned ADC_DATA_W = 10;
   localparam logic [ADC_DATA_W-1:0] ADC_MIDSCALE = 10'd512;

   // Fixed frame: 4 leading zeros, 10 data bits MSB first, 2 trailing zeros.
   localparam int unsigned FRAME_BITS = 16;
   localparam int unsigned LEAD_BITS  = 4;
   localparam int unsigned TRAIL_BITS = 2;

   localparam int unsigned ERR_CNT_W = 8;

   typedef logic [1:0] adc_state_t;
   localparam adc_state_t ST_IDLE    = 2'd0;
   localparam adc_state_t ST_CONVERT = 2'd1;
   localparam adc_state_t ST_QUIET   = 2'd2;

endpackage

// File: rtl/adc_serial_rx_if.sv
// ADC pin and parallel-result bundle; master is the receiver, slave the ADC/consumer side.
interface adc_serial_rx_if;
   import adc_pkg::*;

   logic                  enable;
   logic                  adc_sdata;
   logic                  adc_cs_n;
   logic                  adc_sclk;
   logic [ADC_DATA_W-1:0] adc_dout;
   logic                  sample_valid;
   logic                  frame_err;
   logic [ERR_CNT_W-1:0]  err_count;

   modport master (
      input  enable, adc_sdata,
      output adc_cs_n, adc_sclk, adc_dout, sample_valid, frame_err, err_count
   );

   modport slave (
      output enable, adc_sdata,
      input  adc_cs_n, adc_sclk, adc_dout, sample_valid, frame_err, err_count
   );

endinterface

// File: rtl/adc_sclk_gen.sv
// SCLK generator: half-period divider, glitch-free registered SCLK and rising-edge count.
module adc_sclk_gen import adc_pkg::*; #(
   parameter int unsigned CLK_DIV = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic start,
   output logic sclk,
   output logic busy,
   output logic rise
);

   localparam int unsigned DIV_W  = $clog2(CLK_DIV);
   localparam int unsigned HALF_W = $clog2(2 * FRAME_BITS);
   localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
   localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(2 * FRAME_BITS - 1);

   logic [DIV_W-1:0]  div_q, div_d;
   logic [HALF_W-1:0] half_q, half_d;
   logic              sclk_q, sclk_d;
   logic              busy_q, busy_d;
   logic              tick;

   assign tick = busy_q && (div_q == DIV_LAST);
   // Even half index drives SCLK low, odd index is a rising edge.
   assign rise = tick && half_q[0];

   always_comb begin
      div_d  = div_q;
      half_d = half_q;
      sclk_d = sclk_q;
      busy_d = busy_q;
      if (start) begin
         div_d  = '0;
         half_d = '0;
         sclk_d = 1'b1;
         busy_d = 1'b1;
      end else if (tick) begin
         div_d  = '0;
         half_d = half_q + 1'b1;
         sclk_d = half_q[0];
         if (half_q == HALF_LAST) begin
            busy_d = 1'b0;
         end
      end else if (busy_q) begin
         div_d = div_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_q  <= '0;
         half_q <= '0;
         sclk_q <= 1'b1;
         busy_q <= 1'b0;
      end else begin
         div_q  <= div_d;
         half_q <= half_d;
         sclk_q <= sclk_d;
         busy_q <= busy_d;
      end
   end

   assign sclk = sclk_q;
   assign busy = busy_q;

endmodule

// File: rtl/adc_serial_rx.sv
// Continuous 16-bit-frame serial ADC receiver feeding the over-current detector.
// Optional ADC_ERR_HOLD_EN: errored frames keep the previous code and suppress sample_valid.
module adc_serial_rx import adc_pkg::*; #(
   parameter int unsigned CLK_DIV      = 4,
   parameter int unsigned QUIET_CYCLES = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   adc_serial_rx_if.master bus
);

   localparam int unsigned QW = $clog2(QUIET_CYCLES + 1);
   localparam logic [QW-1:0] QUIET_LAST = QW'(QUIET_CYCLES - 1);
   localparam logic [ERR_CNT_W-1:0] ERR_MAX = '1;

   adc_state_t            state_q, state_d;
   logic [FRAME_BITS-1:0] shift_q, shift_d;
   logic [QW-1:0]         quiet_q, quiet_d;
   logic                  cs_n_q, cs_n_d;
   logic [ADC_DATA_W-1:0] dout_q, dout_d;
   logic                  valid_q, valid_d;
   logic                  ferr_q, ferr_d;
   logic [ERR_CNT_W-1:0]  cnt_q, cnt_d;
   logic                  start, busy, rise, sclk;
   logic                  frame_bad;
   logic [ADC_DATA_W-1:0] frame_code;
   logic                  unused_trail;

   adc_sclk_gen #(
      .CLK_DIV(CLK_DIV)
   ) u_sclk_gen (
      .clk  (clk),
      .rst_n(rst_n),
      .start(start),
      .sclk (sclk),
      .busy (busy),
      .rise (rise)
   );

   assign frame_bad    = |shift_q[FRAME_BITS-1 -: LEAD_BITS];
   assign frame_code   = shift_q[TRAIL_BITS +: ADC_DATA_W];
   assign unused_trail = ^shift_q[TRAIL_BITS-1:0];

   always_comb begin
      start   = 1'b0;
      state_d = state_q;
      shift_d = shift_q;
      quiet_d = quiet_q;
      cs_n_d  = cs_n_q;
      dout_d  = dout_q;
      valid_d = 1'b0;
      ferr_d  = 1'b0;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.enable) begin
               start   = 1'b1;
               cs_n_d  = 1'b0;
               state_d = ST_CONVERT;
            end
         end
         ST_CONVERT: begin
            if (rise) begin
               shift_d = {shift_q[FRAME_BITS-2:0], bus.adc_sdata};
            end
            // Generator drops busy in the cycle after the last rising edge.
            if (!busy) begin
               cs_n_d  = 1'b1;
               quiet_d = '0;
               state_d = ST_QUIET;
               ferr_d  = frame_bad;
               if (frame_bad && (cnt_q != ERR_MAX)) begin
                  cnt_d = cnt_q + 1'b1;
               end
`ifdef ADC_ERR_HOLD_EN
               if (!frame_bad) begin
                  dout_d  = frame_code;
                  valid_d = 1'b1;
               end
`else
               dout_d  = frame_code;
               valid_d = 1'b1;
`endif
            end
         end
         ST_QUIET: begin
            if (quiet_q == QUIET_LAST) begin
               if (bus.enable) begin
                  start   = 1'b1;
                  cs_n_d  = 1'b0;
                  state_d = ST_CONVERT;
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               quiet_d = quiet_q + 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         shift_q <= '0;
         quiet_q <= '0;
         cs_n_q  <= 1'b1;
         dout_q  <= ADC_MIDSCALE;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         quiet_q <= quiet_d;
         cs_n_q  <= cs_n_d;
         dout_q  <= dout_d;
         valid_q <= valid_d;
         ferr_q  <= ferr_d;
         cnt_q   <= cnt_d;
      end
   end

   assign bus.adc_cs_n     = cs_n_q;
   assign bus.adc_sclk     = sclk;
   assign bus.adc_dout     = dout_q;
   assign bus.sample_valid = valid_q;
   assign bus.frame_err    = ferr_q;
   assign bus.err_count    = cnt_q;

endmodule

// File: tb/tb_adc_serial_rx.sv
// Directed bench for adc_serial_rx with a behavioural ADC that shifts on SCLK falling edges.
module tb_adc_serial_rx;

   logic        clk;
   logic        rst_n;
   logic [15:0] adc_frame;
   logic [15:0] cur_frame;
   int          bit_idx;
   int          checks;
   int          errors;

   adc_serial_rx_if bus ();

   adc_serial_rx #(
      .CLK_DIV     (4),
      .QUIET_CYCLES(2)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ADC model: latch the frame at CS fall, present the next bit after every SCLK fall.
   always @(negedge bus.adc_cs_n or negedge bus.adc_sclk) begin
      if (bus.adc_sclk === 1'b1) begin
         cur_frame = adc_frame;
         bit_idx   = 0;
      end else begin
         if (bit_idx < 16) bus.adc_sdata = cur_frame[15 - bit_idx];
         bit_idx++;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // which: 0 = sample_valid, 1 = frame_err, 2 = adc_cs_n low. n = -1 on timeout.
   task automatic wait_sig(input int which, input int max, output int n);
      logic hit;
      n = -1;
      for (int k = 1; k <= max; k++) begin
         tick();
         case (which)
            0:       hit = bus.sample_valid;
            1:       hit = bus.frame_err;
            default: hit = !bus.adc_cs_n;
         endcase
         if (hit) begin
            n = k;
            break;
         end
      end
   endtask

   task automatic measure_frame(output int valid_at, output int edges, output int bad);
      logic prev;
      int   last;
      prev     = bus.adc_sclk;
      last     = 0;
      edges    = 0;
      bad      = 0;
      valid_at = -1;
      for (int k = 1; k <= 200; k++) begin
         tick();
         if (bus.adc_sclk !== prev) begin
            edges++;
            if (k - last != 4) bad++;
            last = k;
            prev = bus.adc_sclk;
         end
         if (bus.sample_valid) begin
            valid_at = k;
            break;
         end
      end
   endtask

   task automatic idle_watch(input int cycles, output int viol);
      viol = 0;
      for (int k = 0; k < cycles; k++) begin
         tick();
         if (bus.adc_cs_n !== 1'b1 || bus.adc_sclk !== 1'b1 || bus.sample_valid !== 1'b0) viol++;
      end
   endtask

   initial begin
      int n, edges, bad, viol, gaps_bad;
      checks     = 0;
      errors     = 0;
      rst_n      = 1'b0;
      bus.enable = 1'b0;
      adc_frame  = 16'h0000;
      repeat (3) tick();
      check("rst_cs_n", 32'(bus.adc_cs_n), 32'd1);
      check("rst_sclk", 32'(bus.adc_sclk), 32'd1);
      check("rst_dout", 32'(bus.adc_dout), 32'd512);
      check("rst_valid", 32'(bus.sample_valid), 32'd0);
      check("rst_ferr", 32'(bus.frame_err), 32'd0);
      check("rst_errcnt", 32'(bus.err_count), 32'd0);

      rst_n = 1'b1;
      idle_watch(500, viol);
      check("idle_viol", 32'(viol), 32'd0);
      check("idle_dout", 32'(bus.adc_dout), 32'd512);

      // Single frame, code 680.
      adc_frame  = {4'b0000, 10'd680, 2'b00};
      bus.enable = 1'b1;
      wait_sig(2, 10, n);
      check("start_lat", 32'(n), 32'd1);
      measure_frame(n, edges, bad);
      check("f680_lat", 32'(n), 32'd129);
      check("f680_edges", 32'(edges), 32'd32);
      check("f680_halfper", 32'(bad), 32'd0);
      check("f680_dout", 32'(bus.adc_dout), 32'd680);
      check("f680_cs_n", 32'(bus.adc_cs_n), 32'd1);
      check("f680_ferr", 32'(bus.frame_err), 32'd0);

      // Continuous frames 0, 1023, 512.
      adc_frame = {4'b0000, 10'd0, 2'b00};
      wait_sig(0, 200, n);
      check("f0_period", 32'(n), 32'd131);
      check("f0_dout", 32'(bus.adc_dout), 32'd0);
      adc_frame = {4'b0000, 10'd1023, 2'b00};
      wait_sig(0, 200, n);
      check("f1023_period", 32'(n), 32'd131);
      check("f1023_dout", 32'(bus.adc_dout), 32'd1023);
      adc_frame = {4'b0000, 10'd512, 2'b11};
      wait_sig(0, 200, n);
      check("f512_period", 32'(n), 32'd131);
      check("f512_dout", 32'(bus.adc_dout), 32'd512);
      check("f512_errcnt", 32'(bus.err_count), 32'd0);

      // Errored frame: leading 0100, code 300.
      adc_frame = {4'b0100, 10'd300, 2'b00};
      wait_sig(1, 200, n);
      check("ferr_period", 32'(n), 32'd131);
      check("ferr_errcnt", 32'(bus.err_count), 32'd1);
`ifdef ADC_ERR_HOLD_EN
      check("ferr_valid", 32'(bus.sample_valid), 32'd0);
      check("ferr_dout", 32'(bus.adc_dout), 32'd512);
`else
      check("ferr_valid", 32'(bus.sample_valid), 32'd1);
      check("ferr_dout", 32'(bus.adc_dout), 32'd300);
`endif
      tick();
      check("ferr_pulse", 32'(bus.frame_err), 32'd0);

      // 299 more errored frames: count saturates at 255.
      gaps_bad = 0;
      for (int i = 1; i <= 299; i++) begin
         wait_sig(1, 200, n);
         if (n != 131 && !(i == 1 && n == 130)) gaps_bad++;
         if (i == 254) check("errcnt_at_255", 32'(bus.err_count), 32'd255);
      end
      check("errburst_gaps", 32'(gaps_bad), 32'd0);
      check("errcnt_sat", 32'(bus.err_count), 32'd255);

      // Drop enable at frame cycle 60: frame completes, then idle.
      adc_frame = {4'b0000, 10'd341, 2'b00};
      wait_sig(2, 10, n);
      check("quiet_len", 32'(n), 32'd2);
      repeat (60) tick();
      bus.enable = 1'b0;
      wait_sig(0, 200, n);
      check("drop_lat", 32'(n), 32'd69);
      check("drop_dout", 32'(bus.adc_dout), 32'd341);
      check("drop_errcnt", 32'(bus.err_count), 32'd255);
      idle_watch(300, viol);
      check("drop_idle_viol", 32'(viol), 32'd0);

      // Reset mid-frame while SCLK is low.
      adc_frame  = {4'b0000, 10'd100, 2'b00};
      bus.enable = 1'b1;
      wait_sig(2, 10, n);
      check("run2_start", 32'(n), 32'd1);
      repeat (54) tick();
      check("run2_sclk_low", 32'(bus.adc_sclk), 32'd0);
      rst_n = 1'b0;
      #1;
      check("mrst_cs_n", 32'(bus.adc_cs_n), 32'd1);
      check("mrst_sclk", 32'(bus.adc_sclk), 32'd1);
      check("mrst_dout", 32'(bus.adc_dout), 32'd512);
      check("mrst_errcnt", 32'(bus.err_count), 32'd0);
      repeat (2) tick();
      rst_n = 1'b1;
      wait_sig(2, 10, n);
      check("post_rst_start", 32'(n), 32'd1);
      measure_frame(n, edges, bad);
      check("post_rst_lat", 32'(n), 32'd129);
      check("post_rst_dout", 32'(bus.adc_dout), 32'd100);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
